// File: rtl/seq_pkg.sv
// Definitions shared by the sequence generator and its matching detector:
// FSM state encoding and default pattern/repeat widths.
package seq_pkg;

  localparam int SEQ_WIDTH = 8;
  localparam int SEQ_RPT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/sequence_generate.sv
// Serial pattern generator: latches a pattern on start and sends it MSB first, with optional
// repetitions separated by idle gaps. First bit one cycle after start; no backpressure, abort exits at once.
module sequence_generate
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int RPT_W = SEQ_RPT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [RPT_W-1:0] repeat_num,
  input  logic [RPT_W-1:0] gap,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done
);

  localparam int            BW      = $clog2(WIDTH);
  localparam logic [BW-1:0] BIT_MSB = BW'(WIDTH - 1);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [RPT_W-1:0] rep_q, rep_d;
  logic [RPT_W-1:0] gap_len_q, gap_len_d;
  logic [RPT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             dout_q, dout_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      rep_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      bit_q     <= '0;
      dout_q    <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      bit_q     <= bit_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Outputs are computed for the cycle being entered, so every output is a flop.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    bit_d     = bit_q;
    dout_d    = 1'b0;
    vld_d     = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_SEND;
          pat_d     = pattern;
          rep_d     = repeat_num;
          gap_len_d = gap;
          bit_d     = BIT_MSB;
          dout_d    = pattern[WIDTH-1];
          vld_d     = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bit_q != '0) begin
          bit_d  = bit_q - BW'(1);
          dout_d = pat_q[bit_d];
          vld_d  = 1'b1;
          busy_d = 1'b1;
        end else if (rep_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          rep_d  = rep_q - RPT_W'(1);
          busy_d = 1'b1;
          if (gap_len_q == '0) begin
            bit_d  = BIT_MSB;
            dout_d = pat_q[WIDTH-1];
            vld_d  = 1'b1;
          end else begin
            // Entering GAP is itself the first idle cycle.
            state_d   = ST_GAP;
            gap_cnt_d = gap_len_q - RPT_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
          if (gap_cnt_q == '0) begin
            state_d = ST_SEND;
            bit_d   = BIT_MSB;
            dout_d  = pat_q[WIDTH-1];
            vld_d   = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - RPT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/sequence_generate.md
SEQUENCE_GENERATE -- requirements
Module: sequence_generate

Interface
REQ-001 SHALL have parameter WIDTH, default 8, serial pattern length in bits (2..16).
REQ-002 SHALL have parameter RPT_W, default 4, width of repeat and gap fields.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to transmit, sampled each clk.
REQ-006 SHALL have port abort  input  1  terminate transmission immediately.
REQ-007 SHALL have port pattern  input  WIDTH  bits to send, MSB first.
REQ-008 SHALL have port repeat_num  input  RPT_W  extra repetitions after the first (0 = send once).
REQ-009 SHALL have port gap  input  RPT_W  idle cycles between repetitions (0 = back-to-back).
REQ-010 SHALL have port dout  output  1  serial data, registered.
REQ-011 SHALL have port dout_vld  output  1  high on every cycle dout carries a pattern bit.
REQ-012 SHALL have port busy  output  1  high from the first bit through the last bit, gaps included.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the final bit of a completed transmission.

Function
REQ-014 SHALL implement states IDLE, SEND and GAP, all outputs registered.
REQ-015 SHALL accept start only in IDLE; start in SEND or GAP is ignored.
REQ-016 SHALL latch pattern, repeat_num and gap on accepting start; later input changes do not affect the transmission in progress.
REQ-017 SHALL drive dout=pattern[WIDTH-1], dout_vld=1 and busy=1 on the cycle after start is accepted (latency 1).
REQ-018 SHALL emit bits WIDTH-1 down to 0 on WIDTH consecutive cycles in SEND, with dout_vld=1 on each.
REQ-019 SHALL, after bit 0 with repetitions remaining and gap>0, enter GAP for exactly gap cycles with dout=0, dout_vld=0, busy=1.
REQ-020 SHALL, after bit 0 with repetitions remaining and gap=0, send the next repetition's MSB on the very next cycle.
REQ-021 SHALL decrement the internal repeat counter once per completed repetition and never wrap it below 0.
REQ-022 SHALL, after bit 0 of the final repetition, return to IDLE with busy=0, dout_vld=0, dout=0 and done=1 for that one cycle.
REQ-023 SHALL accept a start that coincides with done=1, giving no idle cycle between transmissions.
REQ-024 SHALL, on abort in SEND or GAP, go to IDLE next cycle with dout=0, dout_vld=0, busy=0 and no done pulse.
REQ-025 SHALL give abort priority over start when both are high in the same cycle; abort in IDLE has no effect beyond blocking start.
REQ-026 SHALL hold dout=0 whenever dout_vld=0.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, dout=0, dout_vld=0, busy=0, done=0 and clear the bit, gap and repeat counters.
REQ-028 SHALL, on rst mid-transmission, abandon it with no done pulse; rst has priority over abort and start.

Structure
REQ-029 SHALL take the state encoding (IDLE/SEND/GAP) and the default WIDTH/RPT_W from shared package seq_pkg, which the matching detector also uses.
REQ-030 SHALL be a single module with no sub-modules; bit and gap counters are sized $clog2(WIDTH) and RPT_W.

Verification
REQ-031 SHALL cover: pattern=8'b0111_0001, repeat_num=0, start one cycle -> dout 0,1,1,1,0,0,0,1 on cycles 1-8 with vld=1, done on cycle 9.
REQ-032 SHALL cover: repeat_num=2, gap=3 -> three 8-bit bursts separated by 3 vld=0 cycles, busy high 30 cycles, single done.
REQ-033 SHALL cover: repeat_num=1, gap=0 -> 16 contiguous vld cycles, pattern sent twice.
REQ-034 SHALL cover: abort on bit 4, then start held high with abort in the same cycle -> IDLE next cycle, no done, start not accepted.
REQ-035 SHALL cover: start held high continuously -> new transmission begins on the done cycle; pattern changed mid-burst has no effect.
REQ-036 SHALL cover: rst asserted during GAP -> all outputs 0 next cycle; loopback into an 8-bit shift-register detector for 0111_0001 fires exactly once per repetition.
